// File: rtl/ppl_pixel_writer.sv
// Texture-lookup pixel writer: accepts pixels, fetches texels, queues framebuffer writes, double-buffers on vs.
// Latency: valid -> FIFO push 2 cycles, fb_wr_req the cycle after; backpressure via fb_wr_ack, overflow drops and counts.

module ppl_pixel_writer_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    // Callers qualify push/pop, so a push while full only arrives together with a pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) mem_q[wr_ptr_q] <= dat_i;
    end

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
endmodule

module ppl_pixel_writer #(
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_ppl,
    input  logic        rst,
    input  logic        valid,
    input  logic        vs,
    input  logic [19:0] pixel_addr,
    input  logic [12:0] texture_addr,
    output logic [12:0] tex_addr,
    input  logic [15:0] tex_data,
    output logic        fb_wr_req,
    output logic [20:0] fb_wr_addr,
    output logic [15:0] fb_wr_data,
    input  logic        fb_wr_ack,
    output logic        fb_sel,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] drop_cnt
);
    localparam int unsigned NPIX = H_DISP * V_DISP;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} state_t;

    state_t      state_q, state_d;
    logic        vs_q;
    logic        s1_vld_q, s2_vld_q;
    logic [19:0] s1_addr_q, s2_addr_q;
    logic        fb_sel_q, overflow_q;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        swap_en;

    logic        accept, push, pop, push_ok, ovf_drop, drop;
    logic        fifo_full, fifo_empty;
    logic [36:0] fifo_head;

    assign accept   = valid && (state_q == ST_RUN) && (32'(pixel_addr) < NPIX);
    assign tex_addr = accept ? texture_addr : '0;

    // Stage 2 lines up with the ROM's 2-cycle read, so tex_data belongs to s2_addr_q.
    assign push     = s2_vld_q;
    assign pop      = !fifo_empty && fb_wr_ack;
    assign push_ok  = push && (!fifo_full || pop);
    assign ovf_drop = push && fifo_full && !pop;
    assign drop     = (valid && !accept) || ovf_drop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_ppl) begin
        if (rst) begin
            vs_q       <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            fb_sel_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            vs_q       <= vs;
            s1_vld_q   <= accept;
            s1_addr_q  <= pixel_addr;
            s2_vld_q   <= s1_vld_q;
            s2_addr_q  <= s1_addr_q;
            drop_cnt_q <= drop_cnt_d;
            if (ovf_drop) overflow_q <= 1'b1;
            if (swap_en)  fb_sel_q   <= ~fb_sel_q;
        end
    end

    always_ff @(posedge clk_ppl) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (vs && !vs_q) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_vld_q && !s2_vld_q && fifo_empty) state_d = ST_SWAP;
            ST_SWAP:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        swap_en    = (state_q == ST_SWAP);
        frame_done = (state_q == ST_SWAP);
    end

    ppl_pixel_writer_fifo #(
        .W     (37),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_ppl),
        .rst_i   (rst),
        .push_i  (push_ok),
        .dat_i   ({fb_sel_q, s2_addr_q, tex_data}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign fb_wr_req  = !fifo_empty;
    assign fb_wr_addr = fifo_empty ? 21'd0 : fifo_head[36:16];
    assign fb_wr_data = fifo_empty ? 16'd0 : fifo_head[15:0];
    assign fb_sel     = fb_sel_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
endmodule
